// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths, sizing and entry type encodings
package reorder_buffer_pkg;
   localparam int CFG_XLEN     = 32;
   localparam int CFG_TAG_W    = 4;
   localparam int CFG_DEPTH    = 15;
   localparam int CFG_WB_PORTS = 2;
   typedef enum logic [1:0] {
      ROB_NORMAL = 2'd0,
      ROB_BRANCH = 2'd1,
      ROB_STORE  = 2'd2
   } rob_type_e;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, write-back, operand lookup and commit signals of the ROB
interface reorder_buffer_if import reorder_buffer_pkg::*; #(
   parameter int TAG_W    = CFG_TAG_W,
   parameter int WB_PORTS = CFG_WB_PORTS,
   parameter int XLEN     = CFG_XLEN
);
   logic                      rdy;
   logic                      full;
   logic                      alloc_valid;
   rob_type_e                 alloc_type;
   logic [4:0]                alloc_rd;
   logic [XLEN-1:0]           alloc_pred_pc;
   logic [TAG_W-1:0]          alloc_tag;
   logic [WB_PORTS-1:0]       wb_valid;
   logic [WB_PORTS*TAG_W-1:0] wb_tag;
   logic [WB_PORTS*XLEN-1:0]  wb_value;
   logic [WB_PORTS*XLEN-1:0]  wb_next_pc;
   logic [TAG_W-1:0]          qj, qk;
   logic                      vj_valid, vk_valid;
   logic [XLEN-1:0]           vj, vk;
   logic                      commit_valid;
   rob_type_e                 commit_type;
   logic [4:0]                commit_rd;
   logic [XLEN-1:0]           commit_value;
   logic [TAG_W-1:0]          commit_tag;
   logic                      flush;
   logic [XLEN-1:0]           flush_pc;
   modport master (
      output rdy, alloc_valid, alloc_type, alloc_rd, alloc_pred_pc,
      output wb_valid, wb_tag, wb_value, wb_next_pc, qj, qk,
      input  full, alloc_tag, vj_valid, vk_valid, vj, vk,
      input  commit_valid, commit_type, commit_rd, commit_value, commit_tag, flush, flush_pc
   );
   modport slave (
      input  rdy, alloc_valid, alloc_type, alloc_rd, alloc_pred_pc,
      input  wb_valid, wb_tag, wb_value, wb_next_pc, qj, qk,
      output full, alloc_tag, vj_valid, vk_valid, vj, vk,
      output commit_valid, commit_type, commit_rd, commit_value, commit_tag, flush, flush_pc
   );
endinterface

// File: rtl/reorder_buffer_wrap_ptr.sv
// rob_wrap_ptr: circular pointer increment over 1..DEPTH (tag 0 is reserved)
module rob_wrap_ptr import reorder_buffer_pkg::*; #(
   parameter int DEPTH = CFG_DEPTH,
   parameter int TAG_W = CFG_TAG_W
) (
   input  logic [TAG_W-1:0] ptr,
   output logic [TAG_W-1:0] nxt
);
   assign nxt = (ptr == TAG_W'(DEPTH)) ? TAG_W'(1) : ptr + TAG_W'(1);
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement of tagged results, one commit per cycle,
// with a one-cycle flush pulse on a mispredicted branch followed by a full clear.
module reorder_buffer import reorder_buffer_pkg::*; #(
   parameter int DEPTH    = CFG_DEPTH,
   parameter int TAG_W    = CFG_TAG_W,
   parameter int WB_PORTS = CFG_WB_PORTS,
   parameter int XLEN     = CFG_XLEN
) (
   input logic             clk,
   input logic             rst,
   reorder_buffer_if.slave bus
);
   localparam int N = 2 ** TAG_W;
   localparam logic [TAG_W-1:0] ONE  = TAG_W'(1);
   localparam logic [TAG_W-1:0] LAST = TAG_W'(DEPTH);
   logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d, head_nxt, tail_nxt, wt;
   logic [N-1:0]     busy_q, busy_d, ready_q, ready_d;
   rob_type_e        type_q [N], type_d [N];
   logic [4:0]       rd_q [N], rd_d [N];
   logic [XLEN-1:0]  pred_q [N], pred_d [N], value_q [N], value_d [N], npc_q [N], npc_d [N];
   logic             commit_valid_q, commit_valid_d, flush_q, flush_d, do_alloc, do_commit;
   rob_type_e        commit_type_q, commit_type_d;
   logic [4:0]       commit_rd_q, commit_rd_d;
   logic [XLEN-1:0]  commit_value_q, commit_value_d, flush_pc_q, flush_pc_d;
   logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
   logic [XLEN:0]    look_j, look_k;
   rob_wrap_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_head (.ptr(head_q), .nxt(head_nxt));
   rob_wrap_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_tail (.ptr(tail_q), .nxt(tail_nxt));
   // a pending flush swallows the whole cycle: no alloc, write-back or commit
   always_comb begin
      do_commit = bus.rdy && !flush_q && busy_q[head_q] && ready_q[head_q];
      do_alloc  = bus.rdy && !flush_q && bus.alloc_valid && count_q != LAST;
   end
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      count_d = count_q;
      busy_d = busy_q;
      ready_d = ready_q;
      type_d = type_q;
      rd_d = rd_q;
      pred_d = pred_q;
      value_d = value_q;
      npc_d = npc_q;
      commit_valid_d = commit_valid_q;
      flush_d = flush_q;
      commit_type_d = commit_type_q;
      commit_rd_d = commit_rd_q;
      commit_value_d = commit_value_q;
      commit_tag_d = commit_tag_q;
      flush_pc_d = flush_pc_q;
      wt = '0;
      if (bus.rdy) begin
         commit_valid_d = do_commit;
         flush_d = 1'b0;
         if (flush_q) begin
            busy_d = '0;
            ready_d = '0;
            head_d = ONE;
            tail_d = ONE;
            count_d = '0;
         end else begin
            // descending order so the lowest port's write lands last
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
               wt = bus.wb_tag[p*TAG_W +: TAG_W];
               if (bus.wb_valid[p] && busy_q[wt]) begin
                  ready_d[wt] = 1'b1;
                  value_d[wt] = bus.wb_value[p*XLEN +: XLEN];
                  npc_d[wt] = bus.wb_next_pc[p*XLEN +: XLEN];
               end
            end
            if (do_commit) begin
               busy_d[head_q] = 1'b0;
               ready_d[head_q] = 1'b0;
               head_d = head_nxt;
               commit_type_d = type_q[head_q];
               commit_rd_d = rd_q[head_q];
               commit_value_d = value_q[head_q];
               commit_tag_d = head_q;
               flush_d = type_q[head_q] == ROB_BRANCH && npc_q[head_q] != pred_q[head_q];
               flush_pc_d = flush_d ? npc_q[head_q] : flush_pc_q;
            end
            if (do_alloc) begin
               busy_d[tail_q] = 1'b1;
               ready_d[tail_q] = 1'b0;
               type_d[tail_q] = bus.alloc_type;
               rd_d[tail_q] = bus.alloc_type == ROB_NORMAL ? bus.alloc_rd : '0;
               pred_d[tail_q] = bus.alloc_type == ROB_BRANCH ? bus.alloc_pred_pc : '0;
               tail_d = tail_nxt;
            end
            count_d = count_q + TAG_W'(do_alloc) - TAG_W'(do_commit);
         end
      end
      if (rst) begin
         head_d = ONE;
         tail_d = ONE;
         count_d = '0;
         busy_d = '0;
         ready_d = '0;
         commit_valid_d = 1'b0;
         flush_d = 1'b0;
         commit_type_d = ROB_NORMAL;
         commit_rd_d = '0;
         commit_value_d = '0;
         commit_tag_d = '0;
         flush_pc_d = '0;
      end
   end
   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
      type_q <= type_d;
      rd_q <= rd_d;
      pred_q <= pred_d;
      value_q <= value_d;
      npc_q <= npc_d;
      commit_valid_q <= commit_valid_d;
      flush_q <= flush_d;
      commit_type_q <= commit_type_d;
      commit_rd_q <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q <= commit_tag_d;
      flush_pc_q <= flush_pc_d;
   end
   // stored value beats same-cycle bypass; lowest matching port wins the bypass
   always_comb begin
      look_j = '0;
      look_k = '0;
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
         if (bus.wb_valid[p] && bus.wb_tag[p*TAG_W +: TAG_W] == bus.qj) look_j = {1'b1, bus.wb_value[p*XLEN +: XLEN]};
         if (bus.wb_valid[p] && bus.wb_tag[p*TAG_W +: TAG_W] == bus.qk) look_k = {1'b1, bus.wb_value[p*XLEN +: XLEN]};
      end
      if (ready_q[bus.qj]) look_j = {1'b1, value_q[bus.qj]};
      if (ready_q[bus.qk]) look_k = {1'b1, value_q[bus.qk]};
      if (bus.qj == '0) look_j = '0;
      if (bus.qk == '0) look_k = '0;
   end
   assign {bus.vj_valid, bus.vj} = look_j;
   assign {bus.vk_valid, bus.vk} = look_k;
   assign bus.full = count_q == LAST;
   assign bus.alloc_tag = tail_q;
   assign bus.commit_valid = commit_valid_q && bus.rdy;
   assign bus.flush = flush_q && bus.rdy;
   assign bus.commit_type = commit_type_q;
   assign bus.commit_rd = commit_rd_q;
   assign bus.commit_value = commit_value_q;
   assign bus.commit_tag = commit_tag_q;
   assign bus.flush_pc = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random stimulus checked against a program-order queue model
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;
   localparam int D = 15;
   localparam int W = 2;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   reorder_buffer_if bus ();
   reorder_buffer dut (.clk(clk), .rst(rst), .bus(bus));
   logic rdy, av;
   logic [1:0] at;
   logic [4:0] ard;
   logic [31:0] apc;
   logic [W-1:0] wv;
   logic [3:0] wt [W];
   logic [31:0] wval [W], wnpc [W];
   logic [3:0] qj, qk;
   int errors = 0, checks = 0;
   typedef struct {
      int tag;
      int typ;
      int rd;
      logic [31:0] pred;
      logic [31:0] val;
      logic [31:0] npc;
      bit ready;
   } ent_t;
   ent_t rob[$];
   int nxt_tag = 1;
   bit pc_v = 0, pf = 0;
   int pc_typ = 0, pc_rd = 0, pc_tag = 0;
   logic [31:0] pc_val = 0, pf_pc = 0;
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic idle();
      rst = 1'b0; rdy = 1'b1; av = 1'b0; at = 2'd0; ard = '0; apc = '0; wv = '0; qj = '0; qk = '0;
      for (int p = 0; p < W; p++) begin
         wt[p] = '0; wval[p] = '0; wnpc[p] = '0;
      end
   endtask
   task automatic apply();
      bus.rdy = rdy; bus.alloc_valid = av; bus.alloc_type = rob_type_e'(at);
      bus.alloc_rd = ard; bus.alloc_pred_pc = apc; bus.wb_valid = wv; bus.qj = qj; bus.qk = qk;
      for (int p = 0; p < W; p++) begin
         bus.wb_tag[p*4 +: 4] = wt[p];
         bus.wb_value[p*32 +: 32] = wval[p];
         bus.wb_next_pc[p*32 +: 32] = wnpc[p];
      end
   endtask
   function automatic logic [32:0] look(logic [3:0] q);
      if (q == 0) return '0;
      foreach (rob[i]) if (rob[i].tag == int'(q) && rob[i].ready) return {1'b1, rob[i].val};
      for (int p = 0; p < W; p++) if (wv[p] && wt[p] == q) return {1'b1, wval[p]};
      return '0;
   endfunction
   function automatic void model_edge();
      int n;
      if (rst) begin
         rob.delete(); nxt_tag = 1; pc_v = 0; pf = 0;
         pc_typ = 0; pc_rd = 0; pc_tag = 0; pc_val = 0; pf_pc = 0;
         return;
      end
      if (!rdy) return;
      if (pf) begin
         rob.delete(); nxt_tag = 1; pc_v = 0; pf = 0;
         return;
      end
      n = rob.size();
      pc_v = 0; pf = 0;
      if (n > 0 && rob[0].ready) begin
         pc_v = 1; pc_typ = rob[0].typ; pc_rd = rob[0].rd; pc_val = rob[0].val; pc_tag = rob[0].tag;
         if (rob[0].typ == 1 && rob[0].npc != rob[0].pred) begin
            pf = 1; pf_pc = rob[0].npc;
         end
         void'(rob.pop_front());
      end
      foreach (rob[i])
         for (int p = 0; p < W; p++)
            if (wv[p] && int'(wt[p]) == rob[i].tag) begin
               rob[i].ready = 1; rob[i].val = wval[p]; rob[i].npc = wnpc[p];
               break;
            end
      if (av && n < D) begin
         rob.push_back('{tag: nxt_tag, typ: int'(at), rd: (at == 0) ? int'(ard) : 0,
                         pred: (at == 1) ? apc : 32'h0, val: 32'h0, npc: 32'h0, ready: 1'b0});
         nxt_tag = nxt_tag % D + 1;
      end
   endfunction
   task automatic eval_(string tag);
      logic [32:0] ej, ek;
      apply();
      #1;
      ej = look(qj);
      ek = look(qk);
      chk({tag, ":full"}, 64'(bus.full), 64'(rob.size() == D));
      chk({tag, ":alloc_tag"}, 64'(bus.alloc_tag), 64'(nxt_tag));
      chk({tag, ":commit_valid"}, 64'(bus.commit_valid), 64'(pc_v && rdy));
      chk({tag, ":flush"}, 64'(bus.flush), 64'(pf && rdy));
      chk({tag, ":vj_valid"}, 64'(bus.vj_valid), 64'(ej[32]));
      chk({tag, ":vj"}, 64'(bus.vj), 64'(ej[31:0]));
      chk({tag, ":vk_valid"}, 64'(bus.vk_valid), 64'(ek[32]));
      chk({tag, ":vk"}, 64'(bus.vk), 64'(ek[31:0]));
      if (pc_v && rdy) begin
         chk({tag, ":commit_type"}, 64'(bus.commit_type), 64'(pc_typ));
         chk({tag, ":commit_rd"}, 64'(bus.commit_rd), 64'(pc_rd));
         chk({tag, ":commit_value"}, 64'(bus.commit_value), 64'(pc_val));
         chk({tag, ":commit_tag"}, 64'(bus.commit_tag), 64'(pc_tag));
      end
      if (pf && rdy) chk({tag, ":flush_pc"}, 64'(bus.flush_pc), 64'(pf_pc));
   endtask
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      idle();
   endtask
   task automatic cyc(string tag);
      eval_(tag);
      tick();
   endtask
   task automatic do_reset();
      rst = 1'b1;
      cyc("rst");
      eval_("after_rst");
      chk("rst_alloc_tag", 64'(bus.alloc_tag), 64'd1);
      chk("rst_full", 64'(bus.full), 64'd0);
      chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
      chk("rst_flush", 64'(bus.flush), 64'd0);
      tick();
   endtask
   initial begin
      idle();
      rst = 1'b1;
      apply();
      tick();
      do_reset();
      // fill to capacity, sixteenth allocation ignored
      for (int i = 1; i <= D; i++) begin
         av = 1'b1; ard = 5'(i);
         eval_("fill");
         chk("fill_tag", 64'(bus.alloc_tag), 64'(i));
         tick();
      end
      av = 1'b1;
      eval_("alloc16");
      chk("full_after_15", 64'(bus.full), 64'd1);
      tick();
      eval_("post16");
      chk("tag_after_16th", 64'(bus.alloc_tag), 64'd1);
      chk("still_full", 64'(bus.full), 64'd1);
      tick();
      // out-of-order write-back, in-order commit
      do_reset();
      av = 1'b1; cyc("a1");
      av = 1'b1; cyc("a2");
      wv[0] = 1'b1; wt[0] = 4'd2; wval[0] = 32'h22; cyc("wb2");
      wv[0] = 1'b1; wt[0] = 4'd1; wval[0] = 32'h11; cyc("wb1");
      cyc("c_wait");
      eval_("c1");
      chk("c1_valid", 64'(bus.commit_valid), 64'd1);
      chk("c1_tag", 64'(bus.commit_tag), 64'd1);
      chk("c1_value", 64'(bus.commit_value), 64'h11);
      tick();
      eval_("c2");
      chk("c2_valid", 64'(bus.commit_valid), 64'd1);
      chk("c2_tag", 64'(bus.commit_tag), 64'd2);
      chk("c2_value", 64'(bus.commit_value), 64'h22);
      tick();
      eval_("c3");
      chk("c3_idle", 64'(bus.commit_valid), 64'd0);
      tick();
      // lookup bypass, stored value, port priority, tag 0
      do_reset();
      repeat (3) begin av = 1'b1; cyc("a"); end
      wv[1] = 1'b1; wt[1] = 4'd3; wval[1] = 32'hAB; qj = 4'd3;
      eval_("bypass");
      chk("bypass_valid", 64'(bus.vj_valid), 64'd1);
      chk("bypass_vj", 64'(bus.vj), 64'hAB);
      tick();
      qj = 4'd3;
      eval_("stored");
      chk("stored_vj", 64'(bus.vj), 64'hAB);
      tick();
      wv = 2'b11; wt[0] = 4'd2; wt[1] = 4'd2; wval[0] = 32'h55; wval[1] = 32'h66; qk = 4'd2;
      eval_("prio");
      chk("prio_bypass_vk", 64'(bus.vk), 64'h55);
      tick();
      qk = 4'd2;
      eval_("prio_stored");
      chk("prio_stored_vk", 64'(bus.vk), 64'h55);
      tick();
      wv[0] = 1'b1; wt[0] = 4'd0; wval[0] = 32'h77; qj = 4'd0; qk = 4'd1;
      eval_("no_value");
      chk("tag0_vj_valid", 64'(bus.vj_valid), 64'd0);
      chk("notready_vk_valid", 64'(bus.vk_valid), 64'd0);
      chk("notready_vk", 64'(bus.vk), 64'd0);
      tick();
      // mispredicted branch flush
      do_reset();
      av = 1'b1; at = 2'd1; apc = 32'h100; cyc("br");
      av = 1'b1; cyc("a2");
      wv[0] = 1'b1; wt[0] = 4'd1; wnpc[0] = 32'h200; cyc("wb_br");
      cyc("br_wait");
      av = 1'b1; wv[0] = 1'b1; wt[0] = 4'd2; wval[0] = 32'h5;
      eval_("flush");
      chk("flush_commit", 64'(bus.commit_valid), 64'd1);
      chk("flush_pulse", 64'(bus.flush), 64'd1);
      chk("flush_pc", 64'(bus.flush_pc), 64'h200);
      tick();
      qj = 4'd2;
      eval_("post_flush");
      chk("post_flush_tag", 64'(bus.alloc_tag), 64'd1);
      chk("post_flush_full", 64'(bus.full), 64'd0);
      chk("post_flush_pulse", 64'(bus.flush), 64'd0);
      chk("post_flush_vj_valid", 64'(bus.vj_valid), 64'd0);
      tick();
      // correct branch, then store
      av = 1'b1; at = 2'd1; apc = 32'h300; cyc("br_ok");
      av = 1'b1; at = 2'd2; ard = 5'd7; cyc("st");
      wv = 2'b11; wt[0] = 4'd1; wnpc[0] = 32'h300; wt[1] = 4'd2; wval[1] = 32'h99; cyc("wb_both");
      cyc("ok_wait");
      eval_("good_br");
      chk("good_br_commit", 64'(bus.commit_valid), 64'd1);
      chk("good_br_noflush", 64'(bus.flush), 64'd0);
      chk("good_br_type", 64'(bus.commit_type), 64'd1);
      tick();
      eval_("store");
      chk("store_commit", 64'(bus.commit_valid), 64'd1);
      chk("store_type", 64'(bus.commit_type), 64'd2);
      chk("store_value", 64'(bus.commit_value), 64'h99);
      tick();
      // full with simultaneous commit: alloc rejected, then accepted at tag 1
      do_reset();
      repeat (D) begin av = 1'b1; cyc("fill2"); end
      wv[0] = 1'b1; wt[0] = 4'd1; wval[0] = 32'h1; cyc("wb_head");
      av = 1'b1;
      eval_("reject");
      chk("reject_full", 64'(bus.full), 64'd1);
      tick();
      av = 1'b1;
      eval_("accept");
      chk("accept_not_full", 64'(bus.full), 64'd0);
      chk("accept_tag", 64'(bus.alloc_tag), 64'd1);
      tick();
      eval_("wrapped");
      chk("wrapped_tag", 64'(bus.alloc_tag), 64'd2);
      chk("wrapped_full", 64'(bus.full), 64'd1);
      tick();
      // rdy low freezes everything
      do_reset();
      av = 1'b1; cyc("a1");
      wv[0] = 1'b1; wt[0] = 4'd1; wval[0] = 32'h42; cyc("wb1");
      repeat (3) begin
         rdy = 1'b0; av = 1'b1;
         eval_("frozen");
         chk("frozen_commit", 64'(bus.commit_valid), 64'd0);
         chk("frozen_tag", 64'(bus.alloc_tag), 64'd2);
         tick();
      end
      cyc("rdy_back");
      eval_("late_commit");
      chk("late_commit_valid", 64'(bus.commit_valid), 64'd1);
      chk("late_commit_value", 64'(bus.commit_value), 64'h42);
      tick();
      // reset mid-operation discards in-flight entries
      av = 1'b1; cyc("m1");
      wv[0] = 1'b1; wt[0] = 4'd2; wval[0] = 32'h33; cyc("m_wb");
      rst = 1'b1; av = 1'b1; cyc("mid_rst");
      qj = 4'd2;
      eval_("after_mid_rst");
      chk("mid_rst_vj_valid", 64'(bus.vj_valid), 64'd0);
      chk("mid_rst_tag", 64'(bus.alloc_tag), 64'd1);
      tick();
      // random traffic
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         rdy = ($urandom_range(0, 7) != 0);
         av = ($urandom_range(0, 2) != 0);
         at = 2'($urandom_range(0, 2));
         ard = 5'($urandom);
         apc = ($urandom_range(0, 7) != 0) ? 32'h100 : 32'h200;
         for (int p = 0; p < W; p++) begin
            wv[p] = 1'($urandom_range(0, 1));
            wt[p] = 4'($urandom_range(0, 15));
            wval[p] = $urandom;
            wnpc[p] = ($urandom_range(0, 7) != 0) ? 32'h100 : 32'h200;
         end
         qj = 4'($urandom_range(0, 15));
         qk = 4'($urandom_range(0, 15));
         cyc("rnd");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
